// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the IF/ID register and the fetch stage top.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
// A bubble is the all-zero NOP with valid cleared.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pcplus4,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr   <= NOP;
            pcplus4 <= 32'h0;
            valid   <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr   <= load_instr;
                pcplus4 <= load_pcplus4;
                valid   <= 1'b1;
            end else if (bubble) begin
                instr   <= NOP;
                pcplus4 <= 32'h0;
                valid   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem ready handshake, redirects, IF/ID.
// Requests are never aborted; a redirect during a wait drains the old one.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        redirectD,
    input  logic [31:0] redirect_pcD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    fetch_state_t state;
    logic [31:0]  pcF;
    logic [31:0]  pc4;
    logic [31:0]  hold_instr;
    logic [31:0]  tgt;
    logic         hold;
    logic         redirect;
    logic         ld;
    logic         bub;
    logic         keep;
    logic [31:0]  ld_instr;

    assign hold      = stallF | stallD;
    assign redirect  = redirectD & validD & ~stallD;
    assign pc4       = pcF + 32'd4;
    assign imem_addr = pcF;
    assign imem_req  = (state != S_HOLD) & ~reset;
    assign keep      = ~(ld | bub);

    always_comb begin
        ld       = 1'b0;
        bub      = 1'b0;
        ld_instr = imem_rdata;
        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    bub = 1'b1;
                end else if (!hold) begin
                    ld  = imem_ready;
                    bub = ~imem_ready;
                end
            end
            S_HOLD: begin
                if (!hold) begin
                    ld       = ~redirect;
                    bub      = redirect;
                    ld_instr = hold_instr;
                end
            end
            S_DRAIN: bub = ~stallD;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pcF        <= RESET_PC;
            hold_instr <= NOP;
            tgt        <= 32'h0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            pcF <= word_align(redirect_pcD);
                        end else if (!hold) begin
                            pcF <= pc4;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= S_HOLD;
                        end
                    end else if (redirect) begin
                        tgt   <= word_align(redirect_pcD);
                        state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        pcF   <= redirect ? word_align(redirect_pcD) : pc4;
                        state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        pcF   <= tgt;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk          (clk),
        .reset        (reset),
        .load         (ld),
        .bubble       (bub),
        .hold         (keep),
        .load_instr   (ld_instr),
        .load_pcplus4 (pc4),
        .instr        (instrD),
        .pcplus4      (pcplus4D),
        .valid        (validD)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core. It sits directly upstream of decode and consumes stallF/stallD from the hazard unit.
It owns the PC and runs a ready-handshake with instruction memory, which may insert wait states. It applies decode-stage branch/jump redirects and feeds instrD/pcplus4D/validD to decode.
There is no branch delay slot: a taken redirect squashes the fall-through fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
stallF  input  1  hazard unit: hold PC
stallD  input  1  hazard unit: hold IF/ID
redirectD  input  1  decode: taken branch/jump for instruction in D
redirect_pcD  input  32  redirect target; bits [1:0] ignored, forced to 00
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= pcF)
imem_ready  input  1  memory returns imem_rdata for the current request this cycle
imem_rdata  input  32  fetched instruction
instrD  output  32  IF/ID instruction; 32'h0 (sll $0,$0,0 NOP) when bubble
pcplus4D  output  32  IF/ID PC+4
validD  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async): pcF=RESET_PC, state=REQ, instrD=0, pcplus4D=0, validD=0, buffer cleared; imem_req gated low while reset is high.
- hold = stallF | stallD. redirect is only taken when redirectD & validD & !stallD.
- imem_addr = pcF always. imem_req=1 in REQ and DRAIN, 0 in HOLD.
- Requests are non-abortable: imem_addr stays stable from the start of a request until the cycle imem_ready=1.
- State REQ:
  - ready & redirect: drop rdata; pcF<=target; IF/ID<=bubble; stay REQ.
  - ready & !hold: IF/ID<={rdata, pcF+4, 1}; pcF<=pcF+4; stay REQ.
  - ready & hold: buffer<=rdata; IF/ID holds; go HOLD.
  - !ready & redirect: tgt<=target; IF/ID<=bubble; go DRAIN.
  - !ready & !hold: IF/ID<=bubble; pcF holds.
  - !ready & hold: IF/ID holds; pcF holds.
- State HOLD (no request):
  - hold: everything holds.
  - !hold & redirect: discard buffer; pcF<=target; IF/ID<=bubble; go REQ.
  - !hold & !redirect: IF/ID<={buffer, pcF+4, 1}; pcF<=pcF+4; go REQ.
- State DRAIN (wait out killed request at old pcF):
  - ready: drop rdata; pcF<=tgt; go REQ.
  - In all cases: IF/ID<=bubble if !stallD, else holds.
  - validD is 0 throughout, so no redirect can occur in DRAIN.
- Latency: instruction at address A appears on instrD the cycle after imem_ready for A, absent stalls. Zero-wait memory gives 1 instruction/cycle.
- Arithmetic: pcF+4 is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Bubble: instrD=0, validD=0, pcplus4D=0.
- Reset mid-request or mid-HOLD aborts immediately; the buffer is discarded.

Decomposition:
- Shared package: fetch state encoding (REQ, HOLD, DRAIN), NOP constant 32'h0, default RESET_PC.
- One natural sub-module: if_id_reg. It holds instrD/pcplus4D/validD with async reset and three inputs: load (with data), bubble, hold.
- PC, buffer, tgt and the FSM stay in fetch_stage.

Test Plan:
- Reset, then imem_ready=1 every cycle, RESET_PC=0 -> imem_addr 0,4,8,...; instrD matches rdata one cycle later; pcplus4D=4,8,...; validD=1 from first load.
- imem_ready low 2 cycles at addr 0x8 -> imem_addr stays 0x8; validD=0 for 2 cycles; then instr@0x8 with pcplus4D=0xC.
- stallD=stallF=1 in the cycle ready returns for 0xC -> HOLD, imem_req=0, instrD unchanged; release -> instrD=word@0xC, pcplus4D=0x10, next imem_addr=0x10.
- redirectD (validD=1) to 0x103 with ready=1 -> next imem_addr=0x100; rdata dropped; validD=0 next cycle.
- redirectD to 0x200 while request for 0x14 is waiting -> imem_addr stays 0x14 until ready; that data dropped; then imem_addr=0x200; validD=0 throughout.
- RESET_PC=32'hFFFF_FFFC, zero-wait -> second address 0x0. Assert reset during HOLD -> outputs clear asynchronously; first request after release at RESET_PC.
